// File: rtl/scan_cycle_ctrl.sv
// Scan-cycle sequencer: INIT -> IN -> PROG -> OUT, repeated or single-stepped
// through WAIT, with a PROG watchdog that latches into an absorbing fault state.
module scan_cycle_ctrl #(
    parameter int INIT_LEN = 32,
    parameter int IO_LEN   = 16,
    parameter int CNT_W    = 5,
    parameter int NCH      = 2,
    parameter int WDT_W    = 16,
    parameter int SCNT_W   = 16
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              RUN,
    input  logic              SINGLE,
    input  logic              STEP,
    input  logic [NCH-1:0]    CH_DONE,
    input  logic [WDT_W-1:0]  WDT_LIMIT,
    output logic [2:0]        STATE,
    output logic [CNT_W-1:0]  COUNT,
    output logic              START,
    output logic              WR_IMAGE,
    output logic              S_WE,
    output logic              CYCLE_END,
    output logic [SCNT_W-1:0] SCAN_CNT,
    output logic              FAULT
);

    localparam logic [2:0] ST_INIT = 3'b011;
    localparam logic [2:0] ST_IN   = 3'b010;
    localparam logic [2:0] ST_PROG = 3'b001;
    localparam logic [2:0] ST_OUT  = 3'b000;
    localparam logic [2:0] ST_WAIT = 3'b100;
    localparam logic [2:0] ST_FLT  = 3'b111;

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_LEN - 1);
    localparam logic [CNT_W-1:0] IO_LAST   = CNT_W'(IO_LEN - 1);

    logic [2:0]        state_reg,     state_next;
    logic [CNT_W-1:0]  count_reg,     count_next;
    logic              start_reg,     start_next;
    logic              wr_image_reg,  wr_image_next;
    logic              s_we_reg,      s_we_next;
    logic              cycle_end_reg, cycle_end_next;
    logic [SCNT_W-1:0] scan_cnt_reg,  scan_cnt_next;
    logic              fault_reg,     fault_next;
    logic [NCH-1:0]    done_latch_reg, done_latch_next;
    logic [WDT_W-1:0]  wdt_reg,       wdt_next;

    logic [NCH-1:0]    done_seen;
    logic              all_done;
    logic [CNT_W-1:0]  count_inc;
    logic [WDT_W-1:0]  wdt_inc;

    // A channel counts as done if it finished earlier in PROG or finishes now.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_done
            assign done_seen[gi] = done_latch_reg[gi] | CH_DONE[gi];
        end
    endgenerate

    assign all_done  = &done_seen;
    assign count_inc = count_reg + 1'b1;
    assign wdt_inc   = wdt_reg + 1'b1;

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        start_next      = 1'b0;
        wr_image_next   = wr_image_reg;
        s_we_next       = s_we_reg;
        cycle_end_next  = 1'b0;
        scan_cnt_next   = scan_cnt_reg;
        fault_next      = fault_reg;
        done_latch_next = done_latch_reg;
        wdt_next        = wdt_reg;

        case (state_reg)
            ST_INIT: begin
                if (count_reg == INIT_LAST) begin
                    state_next    = ST_IN;
                    count_next    = '0;
                    wr_image_next = 1'b1;
                end else begin
                    count_next = count_inc;
                end
            end
            ST_IN: begin
                wr_image_next = 1'b1;
                if (count_reg == IO_LAST) begin
                    state_next      = ST_PROG;
                    count_next      = '0;
                    wr_image_next   = 1'b0;
                    start_next      = 1'b1;
                    done_latch_next = '0;
                    wdt_next        = '0;
                end else begin
                    count_next = count_inc;
                end
            end
            ST_PROG: begin
                done_latch_next = done_seen;
                wdt_next        = wdt_inc;
                // Completion takes priority over a watchdog expiring in the same cycle.
                if (all_done) begin
                    state_next = ST_OUT;
                    count_next = '0;
                    s_we_next  = 1'b1;
                end else if ((WDT_LIMIT != '0) && (wdt_inc >= WDT_LIMIT)) begin
                    state_next = ST_FLT;
                    fault_next = 1'b1;
                end
            end
            ST_OUT: begin
                s_we_next = 1'b1;
                if (count_reg == IO_LAST) begin
                    s_we_next      = 1'b0;
                    count_next     = '0;
                    scan_cnt_next  = scan_cnt_reg + 1'b1;
                    cycle_end_next = 1'b1;
                    if (SINGLE) begin
                        state_next = ST_WAIT;
                    end else begin
                        state_next    = ST_IN;
                        wr_image_next = 1'b1;
                    end
                end else begin
                    count_next = count_inc;
                end
            end
            ST_WAIT: begin
                if (STEP || !SINGLE) begin
                    state_next    = ST_IN;
                    count_next    = '0;
                    wr_image_next = 1'b1;
                end
            end
            ST_FLT: begin
                fault_next    = 1'b1;
                wr_image_next = 1'b0;
                s_we_next     = 1'b0;
            end
            default: begin
                state_next    = ST_INIT;
                count_next    = '0;
                wr_image_next = 1'b0;
                s_we_next     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_reg      <= ST_INIT;
            count_reg      <= '0;
            start_reg      <= 1'b0;
            wr_image_reg   <= 1'b0;
            s_we_reg       <= 1'b0;
            cycle_end_reg  <= 1'b0;
            scan_cnt_reg   <= '0;
            fault_reg      <= 1'b0;
            done_latch_reg <= '0;
            wdt_reg        <= '0;
        end else if (RUN) begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            start_reg      <= start_next;
            wr_image_reg   <= wr_image_next;
            s_we_reg       <= s_we_next;
            cycle_end_reg  <= cycle_end_next;
            scan_cnt_reg   <= scan_cnt_next;
            fault_reg      <= fault_next;
            done_latch_reg <= done_latch_next;
            wdt_reg        <= wdt_next;
        end else begin
            // Frozen: everything holds, but pulses must not stretch.
            start_reg     <= 1'b0;
            cycle_end_reg <= 1'b0;
        end
    end

    assign STATE     = state_reg;
    assign COUNT     = count_reg;
    assign START     = start_reg;
    assign WR_IMAGE  = wr_image_reg;
    assign S_WE      = s_we_reg;
    assign CYCLE_END = cycle_end_reg;
    assign SCAN_CNT  = scan_cnt_reg;
    assign FAULT     = fault_reg;

endmodule

// File: tb/tb_scan_cycle_ctrl.sv
// Directed bench for scan_cycle_ctrl; a second instance with a 2-bit scan
// counter shares the stimulus to exercise counter wrap.
module tb_scan_cycle_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr, run, single, step;
    logic [1:0]  ch_done;
    logic [15:0] wdt_limit;

    logic [2:0]  state;
    logic [4:0]  count;
    logic        start, wr_image, s_we, cycle_end, fault;
    logic [15:0] scan_cnt;

    logic [2:0]  state2;
    logic [4:0]  count2;
    logic        start2, wr2, swe2, ce2, fault2;
    logic [1:0]  scan2;

    scan_cycle_ctrl dut (
        .CLK(clk), .CLR(clr), .RUN(run), .SINGLE(single), .STEP(step),
        .CH_DONE(ch_done), .WDT_LIMIT(wdt_limit),
        .STATE(state), .COUNT(count), .START(start), .WR_IMAGE(wr_image),
        .S_WE(s_we), .CYCLE_END(cycle_end), .SCAN_CNT(scan_cnt), .FAULT(fault)
    );

    scan_cycle_ctrl #(.SCNT_W(2)) dut2 (
        .CLK(clk), .CLR(clr), .RUN(run), .SINGLE(single), .STEP(step),
        .CH_DONE(ch_done), .WDT_LIMIT(wdt_limit),
        .STATE(state2), .COUNT(count2), .START(start2), .WR_IMAGE(wr2),
        .S_WE(swe2), .CYCLE_END(ce2), .SCAN_CNT(scan2), .FAULT(fault2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int wr_tot = 0;
    int swe_tot = 0;
    int start_tot = 0;
    int exp_q[$];
    int exp2_q[$];

    // Enabled-cycle tallies, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (wr_image && run) wr_tot <= wr_tot + 1;
        if (s_we && run) swe_tot <= swe_tot + 1;
        if (start) start_tot <= start_tot + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0:       return start;
            1:       return cycle_end;
            2:       return state == 3'b010;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int limit, output int n);
        n = 0;
        while (!cond(sel) && n < limit) begin
            cyc();
            n++;
        end
    endtask

    // Called right after PROG exits; pops the scoreboard at CYCLE_END.
    task automatic scan_end(input string tag);
        int n;
        int e;
        int e2;
        wait_for(1, 40, n);
        check({tag, "_out_len"}, n, 16);
        check({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0 && exp2_q.size() > 0) begin
            e  = exp_q.pop_front();
            e2 = exp2_q.pop_front();
            check({tag, "_scan_cnt"}, scan_cnt, e);
            check({tag, "_scan_cnt_w2"}, scan2, e2);
        end
        check({tag, "_swe_off"}, s_we, 0);
    endtask

    initial begin
        int n;
        int t_wr;
        int t_swe;
        int t_st;
        clr = 1'b1; run = 1'b1; single = 1'b0; step = 1'b0;
        ch_done = 2'b00; wdt_limit = 16'd0;
        cyc(); cyc();
        check("rst_state", state, 3'b011);
        check("rst_count", count, 0);
        check("rst_start", start, 0);
        check("rst_wr", wr_image, 0);
        check("rst_swe", s_we, 0);
        check("rst_ce", cycle_end, 0);
        check("rst_scan", scan_cnt, 0);
        check("rst_fault", fault, 0);
        check("rst_state_w2", state2, 3'b011);
        check("rst_count_w2", count2, 0);
        check("rst_pulses_w2", {start2, wr2, swe2, ce2, fault2}, 0);
        check("rst_scan_w2", scan2, 0);

        clr = 1'b0;
        wait_for(2, 100, n);
        check("init_len", n, 32);
        check("in_wr", wr_image, 1);
        check("in_count", count, 0);

        // Scan 1: all channels already done when PROG starts.
        t_wr = wr_tot; t_swe = swe_tot; t_st = start_tot;
        ch_done = 2'b11;
        exp_q.push_back(1); exp2_q.push_back(1);
        wait_for(0, 40, n);
        check("s1_in_len", n, 16);
        check("s1_prog", state, 3'b001);
        check("s1_wr_off", wr_image, 0);
        cyc();
        check("s1_prog_exit", state, 3'b000);
        check("s1_start_one", start, 0);
        check("s1_swe_on", s_we, 1);
        scan_end("s1");
        check("s1_wr_cycles", wr_tot - t_wr, 16);
        check("s1_swe_cycles", swe_tot - t_swe, 16);
        check("s1_start_count", start_tot - t_st, 1);
        check("s1_next_in", state, 3'b010);
        check("s1_next_wr", wr_image, 1);

        // Scan 2: channel 0 done at PROG cycle 3, channel 1 at cycle 7.
        ch_done = 2'b00;
        exp_q.push_back(2); exp2_q.push_back(2);
        wait_for(0, 40, n);
        check("s2_in_len", n, 16);
        for (int k = 1; k <= 7; k++) begin
            ch_done = (k == 3) ? 2'b01 : ((k == 7) ? 2'b10 : 2'b00);
            cyc();
            check($sformatf("s2_prog_c%0d", k), state, (k == 7) ? 3'b000 : 3'b001);
        end
        ch_done = 2'b00;
        scan_end("s2");

        // Scan 3: freeze for 5 cycles at IN COUNT=7, then freeze on START.
        t_wr = wr_tot;
        ch_done = 2'b11;
        exp_q.push_back(3); exp2_q.push_back(3);
        repeat (7) cyc();
        check("s3_cnt7", count, 7);
        run = 1'b0;
        repeat (5) cyc();
        check("s3_frz_count", count, 7);
        check("s3_frz_state", state, 3'b010);
        check("s3_frz_start", start, 0);
        run = 1'b1;
        wait_for(0, 40, n);
        check("s3_rest_len", n, 9);
        check("s3_wr_total", wr_tot - t_wr, 16);
        run = 1'b0;
        cyc();
        check("s3_start_forced", start, 0);
        check("s3_frz_prog", state, 3'b001);
        run = 1'b1;
        cyc();
        check("s3_out", state, 3'b000);
        scan_end("s3");

        // Scan 4: SINGLE toggled away from the last OUT cycle is ignored.
        exp_q.push_back(4); exp2_q.push_back(0);
        wait_for(0, 40, n);
        single = 1'b1;
        cyc();
        single = 1'b0;
        scan_end("s4");
        check("s4_next_in", state, 3'b010);

        // Scan 5: SINGLE held through the last OUT cycle parks in WAIT.
        exp_q.push_back(5); exp2_q.push_back(1);
        wait_for(0, 40, n);
        cyc();
        single = 1'b1;
        scan_end("s5");
        check("s5_wait", state, 3'b100);
        n = 0;
        repeat (50) begin
            cyc();
            if (state == 3'b100 && !wr_image) n++;
        end
        check("wait_hold", n, 50);
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("step_in", state, 3'b010);
        check("step_count", count, 0);
        check("step_wr", wr_image, 1);

        // Watchdog expiry with no channel completing.
        single = 1'b0; ch_done = 2'b00; wdt_limit = 16'd10;
        wait_for(0, 40, n);
        check("wdt_in_len", n, 16);
        repeat (9) cyc();
        check("wdt_c9_prog", state, 3'b001);
        cyc();
        check("wdt_flt", state, 3'b111);
        check("wdt_fault", fault, 1);
        check("wdt_flt_outs", {start, wr_image, s_we, cycle_end}, 0);
        ch_done = 2'b11;
        n = 0;
        repeat (100) begin
            cyc();
            if (state == 3'b111 && fault && !start && !wr_image && !s_we && !cycle_end) n++;
        end
        check("flt_hold", n, 100);

        // Reset wins even while frozen.
        run = 1'b0; clr = 1'b1;
        cyc();
        check("clr_state", state, 3'b011);
        check("clr_count", count, 0);
        check("clr_fault", fault, 0);
        check("clr_scan", scan_cnt, 0);
        check("clr_scan_w2", scan2, 0);
        clr = 1'b0; run = 1'b1;
        wait_for(2, 100, n);
        check("clr_init_len", n, 32);

        // Completion on the same cycle the watchdog expires goes to OUT.
        ch_done = 2'b00;
        exp_q.push_back(1); exp2_q.push_back(1);
        wait_for(0, 40, n);
        repeat (9) cyc();
        check("tie_c9_prog", state, 3'b001);
        ch_done = 2'b11;
        cyc();
        check("tie_out", state, 3'b000);
        check("tie_no_fault", fault, 0);
        scan_end("tie");
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_cycle_ctrl.md
SCAN_CYCLE_CTRL -- requirements
Module: scan_cycle_ctrl

Interface
REQ-001 SHALL have parameter INIT_LEN, default 32, INIT phase length in cycles (1..2^CNT_W).
REQ-002 SHALL have parameter IO_LEN, default 16, IN and OUT phase length in cycles (1..2^CNT_W).
REQ-003 SHALL have parameter CNT_W, default 5, phase counter width.
REQ-004 SHALL have parameter NCH, default 2, number of program-engine done channels (1..8).
REQ-005 SHALL have parameter WDT_W, default 16, watchdog counter width.
REQ-006 SHALL have parameter SCNT_W, default 16, scan counter width.
REQ-007 SHALL have ports (name  direction  width  meaning):
- CLK  in  1  single clock, all logic on rising edge
- CLR  in  1  reset, synchronous, active-high
- RUN  in  1  enable; low freezes the controller
- SINGLE  in  1  single-scan mode
- STEP  in  1  in WAIT, starts the next scan
- CH_DONE  in  NCH  per-channel program-complete flags
- WDT_LIMIT  in  WDT_W  PROG timeout in cycles; 0 disables it
- STATE  out  3  current state
- COUNT  out  CNT_W  phase counter
- START  out  1  one-cycle program start pulse
- WR_IMAGE  out  1  input-image write enable
- S_WE  out  1  output-image write enable
- CYCLE_END  out  1  one-cycle end-of-scan pulse
- SCAN_CNT  out  SCNT_W  completed scans
- FAULT  out  1  watchdog fault, sticky

Function
REQ-008 SHALL use state encoding INIT=3'b011, IN=3'b010, PROG=3'b001, OUT=3'b000, WAIT=3'b100, FLT=3'b111; any other value SHALL go to INIT with COUNT=0 on the next enabled cycle.
REQ-009 SHALL update no register while RUN=0, except that START and CYCLE_END are forced to 0.
REQ-010 In INIT, COUNT SHALL increment each cycle; at COUNT==INIT_LEN-1: next state IN, COUNT<=0, WR_IMAGE<=1.
REQ-011 In IN, WR_IMAGE SHALL be 1 and COUNT SHALL increment; at COUNT==IO_LEN-1: next state PROG, COUNT<=0, WR_IMAGE<=0, START<=1 for exactly one cycle, done latches and watchdog cleared.
REQ-012 In PROG, a sticky per-channel latch SHALL capture CH_DONE; all-done is (latch|CH_DONE)=={NCH{1}}, evaluated the same cycle.
REQ-013 On all-done in PROG: next state OUT, COUNT<=0, S_WE<=1.
REQ-014 The watchdog SHALL increment each PROG cycle; if WDT_LIMIT!=0 and the count reaches WDT_LIMIT without all-done, next state SHALL be FLT; all-done in the same cycle wins.
REQ-015 In OUT, S_WE SHALL be 1 and COUNT SHALL increment; at COUNT==IO_LEN-1: S_WE<=0, COUNT<=0, SCAN_CNT<=SCAN_CNT+1 (wraps modulo 2^SCNT_W), CYCLE_END<=1 for one cycle; next state WAIT if SINGLE=1, else IN with WR_IMAGE<=1.
REQ-016 In WAIT, the state SHALL hold until STEP=1 or SINGLE=0, then go to IN with COUNT=0 and WR_IMAGE<=1.
REQ-017 FLT SHALL be absorbing until CLR; in FLT, FAULT=1 and START, WR_IMAGE, S_WE and CYCLE_END are 0.
REQ-018 SINGLE SHALL be sampled only at the last OUT cycle; changes elsewhere have no effect.
REQ-019 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-020 CLR=1 SHALL set on the next edge, regardless of RUN or state: STATE=INIT, COUNT=0, START=0, WR_IMAGE=0, S_WE=0, CYCLE_END=0, SCAN_CNT=0, FAULT=0, done latches=0, watchdog=0.
REQ-021 CLR asserted mid-scan (any state, including FLT) SHALL restart from INIT with the full INIT_LEN delay.

Verification
REQ-022 Defaults, RUN=1, CH_DONE=2'b11 after START -> IN entered 32 cycles after CLR release, WR_IMAGE high 16 cycles, START one pulse, PROG exits next cycle, S_WE high 16 cycles, CYCLE_END pulse, SCAN_CNT=1.
REQ-023 CH_DONE[0] pulsed at PROG cycle 3, CH_DONE[1] pulsed at cycle 7 -> OUT entered after cycle 7.
REQ-024 WDT_LIMIT=10, CH_DONE=0 -> FLT after 10 PROG cycles, FAULT=1; FAULT stays 1 for 100 cycles; CLR -> INIT.
REQ-025 SINGLE=1 -> WAIT after the first OUT; no IN for 50 cycles; one-cycle STEP -> IN next cycle.
REQ-026 RUN=0 for 5 cycles mid-IN at COUNT=7 -> COUNT holds 7 and START stays 0; the phase then completes with 16 WR_IMAGE cycles total.
REQ-027 SCNT_W=2, five scans -> SCAN_CNT sequence 1,2,3,0,1.
